// File: rtl/decode_queue.sv
// decode_queue: buffered MIPS main-decode stage between fetch and ID/EX.
// Each accepted instruction is decoded on enqueue into a 17-bit control
// bundle and stored with its PC, raw word and delay-slot flag in a
// DEPTH-entry FIFO. Outputs always present the head entry.
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   flush                drop all entries and clear delay-slot tracking
//   inst_valid/ready     fetch-side handshake; inst, inst_pc payload
//   dec_valid/ready      consumer-side handshake
//   dec_inst, dec_pc     head instruction word and PC
//   dec_ctrl             head control bundle
//                        [16:0] = regwrite regdst alusrc branch memen memtoreg
//                                 jump jal jr bal hilowrite breakk syscall ri
//                                 eret mtc0 mfc0
//   dec_in_ds            head sits in a branch/jump delay slot
//   count                occupancy
module decode_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned PC_W       = 32,
   parameter bit          ENABLE_CP0 = 1'b1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic                         inst_valid,
   output logic                         inst_ready,
   input  logic [31:0]                  inst,
   input  logic [PC_W-1:0]              inst_pc,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [31:0]                  dec_inst,
   output logic [PC_W-1:0]              dec_pc,
   output logic [16:0]                  dec_ctrl,
   output logic                         dec_in_ds,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned CTRL_W = 17;

   // branch | jump | jal | jr | bal
   localparam logic [CTRL_W-1:0] CT_MASK = 17'h02780;

   typedef struct packed {
      logic [31:0]       inst;
      logic [PC_W-1:0]   pc;
      logic [CTRL_W-1:0] ctrl;
      logic              in_ds;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               lastct;
   logic [CTRL_W-1:0]  enq_ctrl;
   logic               enq;
   logic               deq;
   entry_t             head;

   // Main decoder: raw word to control bundle.
   function automatic logic [CTRL_W-1:0] decode(input logic [31:0] w);
      logic [5:0]        op;
      logic [5:0]        fn;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [CTRL_W-1:0] c;
      op = w[31:26];
      rs = w[25:21];
      rt = w[20:16];
      fn = w[5:0];
      c  = 17'h00008;
      case (op)
         6'h00: begin
            case (fn)
               6'h10, 6'h12:                      c = 17'h18040;
               6'h11, 6'h13, 6'h18, 6'h19,
               6'h1a, 6'h1b:                      c = 17'h00040;
               6'h08:                             c = 17'h00100;
               6'h09:                             c = 17'h18100;
               6'h0d:                             c = 17'h00020;
               6'h0c:                             c = 17'h00010;
               default:                           c = 17'h18000;
            endcase
         end
         6'h1c:                                   c = 17'h18000;
         6'h08, 6'h09, 6'h0a, 6'h0b,
         6'h0c, 6'h0d, 6'h0e, 6'h0f:              c = 17'h14000;
         6'h04, 6'h05, 6'h06, 6'h07:              c = 17'h02000;
         6'h01: begin
            case (rt)
               5'h00, 5'h01:                      c = 17'h02000;
               5'h10, 5'h11:                      c = 17'h12080;
               default:                           c = 17'h00000;
            endcase
         end
         6'h02:                                   c = 17'h00400;
         6'h03:                                   c = 17'h10200;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25:       c = 17'h15800;
         6'h28, 6'h29, 6'h2b:                     c = 17'h05000;
         6'h10: begin
            if (ENABLE_CP0) begin
               if (w == 32'h42000018)             c = 17'h00004;
               else if (rs == 5'b00100)           c = 17'h00002;
               else if (rs == 5'b00000)           c = 17'h10001;
               else                               c = 17'h00008;
            end
         end
         default:                                 c = 17'h00008;
      endcase
      return c;
   endfunction

   // Handshakes and head selection.
   always_comb begin
      enq_ctrl   = decode(inst);
      inst_ready = (count < CNT_W'(DEPTH)) && !flush;
      dec_valid  = (count != '0);
      enq        = inst_valid && inst_ready;
      deq        = dec_valid && dec_ready;
      head       = mem[rd_ptr];
   end

   assign dec_inst  = head.inst;
   assign dec_pc    = head.pc;
   assign dec_ctrl  = head.ctrl;
   assign dec_in_ds = head.in_ds;

   // FIFO storage, pointers, occupancy and delay-slot tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         lastct <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         lastct <= 1'b0;
      end else begin
         if (enq) begin
            mem[wr_ptr] <= '{inst: inst, pc: inst_pc, ctrl: enq_ctrl, in_ds: lastct};
            wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
            lastct      <= |(enq_ctrl & CT_MASK);
         end
         if (deq) begin
            rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         end
         case ({enq, deq})
            2'b10:   count <= CNT_W'(count + 1'b1);
            2'b01:   count <= CNT_W'(count - 1'b1);
            default: count <= count;
         endcase
      end
   end

endmodule
